// File: rtl/seq_alu.sv
// Clocked ALU with a Start/Ready/Done handshake. Most ops finish in one cycle.
// Shifts take one bit per cycle and MUL takes one shift-add step per cycle.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int IMM_W = 3,
  parameter int OP_W  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic             Ready,
  input  logic [OP_W-1:0]  OP,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [IMM_W-1:0] Im,
  output logic [WIDTH-1:0] Out,
  output logic             Branch,
  output logic             Zero,
  output logic             Carry,
  output logic             Done
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LSH  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_RSH  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_GEQ  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_EQ   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_NEQ  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BNZ  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);

  // The counter must hold both the largest shift amount and WIDTH.
  localparam int CNT_W = (IMM_W > $clog2(WIDTH + 1)) ? IMM_W : $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [OP_W-1:0]      op_q;
  logic [WIDTH-1:0]     work_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     out_q;
  logic                 branch_q, zero_q, carry_q, done_q;

  logic [WIDTH:0]       add_sum_d, imm_sum_d, hi_sum_d;
  logic [WIDTH-1:0]     res_d, shl_d, rsh_d, run_res_d;
  logic [2*WIDTH-1:0]   mul_d;
  logic                 carry_d, branch_d, multi_d, run_carry_d, last_d;

  always_comb begin
    add_sum_d = {1'b0, InputA} + {1'b0, InputB};
    imm_sum_d = {1'b0, InputA} + (WIDTH + 1)'(Im);
    res_d     = '0;
    carry_d   = 1'b0;
    branch_d  = 1'b0;
    multi_d   = 1'b0;
    case (OP)
      OP_ADD:  {carry_d, res_d} = add_sum_d;
      OP_ADDI: {carry_d, res_d} = imm_sum_d;
      OP_LSH, OP_RSH: begin
        res_d   = InputA;
        multi_d = (Im != '0);
      end
      OP_AND:  res_d = InputA & InputB;
      OP_OR:   res_d = InputA | InputB;
      OP_NEG:  res_d = ~InputA + WIDTH'(1);
      OP_GEQ:  res_d = {{(WIDTH-1){1'b0}}, (InputA >= InputB)};
      OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
      OP_NEQ:  res_d = {{(WIDTH-1){1'b0}}, (InputA != InputB)};
      OP_BNZ:  branch_d = (InputA != '0);
      OP_MUL:  multi_d = 1'b1;
      default: res_d = '0;
    endcase
  end

  // One iteration step: acc holds {partial high, remaining multiplier bits}.
  always_comb begin
    shl_d    = {work_q[WIDTH-2:0], 1'b0};
    rsh_d    = {1'b0, work_q[WIDTH-1:1]};
    hi_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, work_q} : '0);
    mul_d    = {hi_sum_d, acc_q[WIDTH-1:1]};
    last_d   = (cnt_q == CNT_W'(1));
    run_res_d   = '0;
    run_carry_d = 1'b0;
    if (op_q == OP_MUL) begin
      run_res_d   = mul_d[WIDTH-1:0];
      run_carry_d = |mul_d[2*WIDTH-1:WIDTH];
    end else if (op_q == OP_LSH) begin
      run_res_d   = shl_d;
      run_carry_d = work_q[WIDTH-1];
    end else begin
      run_res_d   = rsh_d;
      run_carry_d = work_q[0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      branch_q <= 1'b0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q   <= OP;
            work_q <= InputA;
            acc_q  <= {{WIDTH{1'b0}}, InputB};
            if (multi_d) begin
              state_q <= RUN;
              cnt_q   <= (OP == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(Im);
            end else begin
              out_q    <= res_d;
              zero_q   <= (res_d == '0);
              carry_q  <= carry_d;
              branch_q <= branch_d;
              done_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_q == OP_MUL) acc_q <= mul_d;
          else work_q <= (op_q == OP_LSH) ? shl_d : rsh_d;
          if (last_d) begin
            state_q  <= IDLE;
            out_q    <= run_res_d;
            zero_q   <= (run_res_d == '0);
            carry_q  <= run_carry_d;
            branch_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Ready  = (state_q == IDLE);
  assign Out    = out_q;
  assign Branch = branch_q;
  assign Zero   = zero_q;
  assign Carry  = carry_q;
  assign Done   = done_q;

endmodule
